// File: rtl/id_issue_queue.sv
// Decoded-instruction issue queue: a circular buffer between the decoder and issue.
// The head is only ever driven from registered storage, so a pushed entry appears at the earliest one cycle after its push.

package id_issue_queue_pkg;

  localparam int unsigned PcW     = 32;
  localparam int unsigned FuW     = 4;
  localparam int unsigned OpW     = 7;
  localparam int unsigned RegIdxW = 5;
  localparam int unsigned DataW   = 32;

  // Decoded instruction as handed from decode to issue
  typedef struct packed {
    logic [PcW-1:0]     pc;
    logic [FuW-1:0]     fu;
    logic [OpW-1:0]     op;
    logic [RegIdxW-1:0] rs1;
    logic [RegIdxW-1:0] rs2;
    logic [RegIdxW-1:0] rd;
    logic               use_imm;
    logic [DataW-1:0]   result;
  } scoreboard_entry_t;

endpackage

module id_issue_queue
  import id_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  scoreboard_entry_t          instr_i,
  input  logic                       instr_valid_i,
  input  logic                       is_ctrl_flow_i,
  output logic                       instr_ready_o,
  output scoreboard_entry_t          decoded_instr_o,
  output logic                       decoded_instr_valid_o,
  output logic                       is_ctrl_flow_o,
  input  logic                       decoded_instr_ack_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  // Entry storage (no reset: contents are meaningless until written)
  scoreboard_entry_t mem_q  [DEPTH];
  logic              ctrl_q [DEPTH];

  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q,    cnt_d;

  logic push;
  logic pop;
  logic ready;
  logic head_valid;

  // Handshake qualifiers: ready looks only at registered occupancy, never at the ack
  always_comb begin
    ready      = (cnt_q < CntW'(DEPTH));
    head_valid = (cnt_q != CntW'(0)) && !flush_i;
    push       = instr_valid_i && ready && !flush_i;
    pop        = decoded_instr_ack_i && head_valid;
  end

  // Pointer and occupancy next-state; flush overrides any same-cycle push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = AddrW'(0);
      rd_ptr_d = AddrW'(0);
      cnt_d    = CntW'(0);
    end else begin
      if (push) wr_ptr_d = AddrW'(wr_ptr_q + AddrW'(1));
      if (pop)  rd_ptr_d = AddrW'(rd_ptr_q + AddrW'(1));
      unique case ({push, pop})
        2'b10:   cnt_d = CntW'(cnt_q + CntW'(1));
        2'b01:   cnt_d = CntW'(cnt_q - CntW'(1));
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= AddrW'(0);
      rd_ptr_q <= AddrW'(0);
      cnt_q    <= CntW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Write the accepted entry at the write pointer
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q]  <= instr_i;
      ctrl_q[wr_ptr_q] <= is_ctrl_flow_i;
    end
  end

  // Head presentation straight from storage at the read pointer
  always_comb begin
    instr_ready_o         = ready;
    decoded_instr_valid_o = head_valid;
    decoded_instr_o       = mem_q[rd_ptr_q];
    is_ctrl_flow_o        = ctrl_q[rd_ptr_q];
    count_o               = cnt_q;
  end

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue: stimulus queues expected heads, a monitor checks every pop.

module tb_id_issue_queue;
  import id_issue_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    scoreboard_entry_t e;
    logic              c;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              flush;
  scoreboard_entry_t instr;
  logic              instr_valid;
  logic              is_ctrl;
  logic              ready;
  scoreboard_entry_t dec_instr;
  logic              dec_valid;
  logic              dec_ctrl;
  logic              ack;
  logic [2:0]        count;

  int   n_vec;
  int   n_err;
  exp_t exp_q[$];

  id_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .flush_i              (flush),
    .instr_i              (instr),
    .instr_valid_i        (instr_valid),
    .is_ctrl_flow_i       (is_ctrl),
    .instr_ready_o        (ready),
    .decoded_instr_o      (dec_instr),
    .decoded_instr_valid_o(dec_valid),
    .is_ctrl_flow_o       (dec_ctrl),
    .decoded_instr_ack_i  (ack),
    .count_o              (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every field is derived from the pc so a corrupted field shows up in the compare
  function automatic scoreboard_entry_t mk_entry(input logic [31:0] pc);
    scoreboard_entry_t e;
    e.pc      = pc;
    e.fu      = pc[5:2];
    e.op      = pc[8:2];
    e.rs1     = pc[7:3];
    e.rs2     = pc[4:0];
    e.rd      = pc[6:2];
    e.use_imm = pc[2];
    e.result  = ~pc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one input vector; a push the bench knows will be accepted is queued as expected
  task automatic drive(input logic v, input logic [31:0] pc, input logic c,
                       input logic a, input logic expect_accept);
    instr_valid = v;
    instr       = mk_entry(pc);
    is_ctrl     = c;
    ack         = a;
    if (expect_accept) exp_q.push_back('{e: mk_entry(pc), c: c});
  endtask

  // Monitor: on every pop compare the head against the oldest expected entry
  always @(negedge clk) begin
    if (dec_valid && ack) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pop: got pc 0x%0h, expected no entry at %0t", dec_instr.pc, $time);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        if (dec_instr !== x.e || dec_ctrl !== x.c) begin
          n_err++;
          $display("FAIL pop_entry: got pc 0x%0h ctrl %0b entry %h, expected pc 0x%0h ctrl %0b entry %h at %0t",
                   dec_instr.pc, dec_ctrl, dec_instr, x.e.pc, x.c, x.e, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single push with ack held: visible next cycle, popped, count back to 0
    step(); drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("nofall_valid", 32'(dec_valid), 32'd0);
    chk("nofall_count", 32'(count), 32'd0);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("a_valid", 32'(dec_valid), 32'd1);
    chk("a_count", 32'(count), 32'd1);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("a_count_after", 32'(count), 32'd0);
    chk("a_valid_after", 32'(dec_valid), 32'd0);

    // Fill to DEPTH, drop a fifth push, one pop frees a slot
    for (int k = 0; k < 4; k++) begin
      step(); drive(1'b1, 32'h200 + 32'(4 * k), 1'b0, 1'b0, 1'b1);
    end
    step(); drive(1'b1, 32'h2F0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(ready), 32'd0);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("drop_count", 32'(count), 32'd4);
    chk("pop_full_ready", 32'(ready), 32'd0);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("after_pop_count", 32'(count), 32'd3);
    chk("after_pop_ready", 32'(ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain_count", 32'(count), 32'd0);

    // Streaming push+ack for 10 cycles across pointer wrap
    for (int i = 0; i < 10; i++) begin
      step(); drive(1'b1, 32'(4 * i), 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      if (i > 0) chk("stream_count", 32'(count), 32'd1);
    end
    step(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stream_end_count", 32'(count), 32'd0);

    // Flush with three entries plus a simultaneous push and ack
    for (int k = 0; k < 3; k++) begin
      step(); drive(1'b1, 32'h300 + 32'(4 * k), 1'b0, 1'b0, 1'b1);
    end
    step();
    flush = 1'b1;
    drive(1'b1, 32'h3FF, 1'b0, 1'b1, 1'b0);
    exp_q.delete();
    @(negedge clk);
    chk("flush_valid", 32'(dec_valid), 32'd0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_ready", 32'(ready), 32'd1);
    step(); drive(1'b1, 32'h310, 1'b0, 1'b0, 1'b1);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Control-flow flag follows its entry; head stable while ack held low
    step(); drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b1);
    step(); drive(1'b1, 32'h404, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("hold_pc", dec_instr.pc, 32'h400);
      chk("hold_ctrl", 32'(dec_ctrl), 32'd1);
      chk("hold_valid", 32'(dec_valid), 32'd1);
    end
    step(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("next_ctrl", 32'(dec_ctrl), 32'd0);
    chk("next_pc", dec_instr.pc, 32'h404);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset with two entries buffered, then order after release
    step(); drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b1);
    step(); drive(1'b1, 32'h504, 1'b0, 1'b0, 1'b1);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_valid", 32'(dec_valid), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(); drive(1'b1, 32'h600, 1'b1, 1'b0, 1'b1);
    step(); drive(1'b1, 32'h604, 1'b0, 1'b0, 1'b1);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("final_count", 32'(count), 32'd0);
    chk("exp_queue_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_issue_queue.md
ID_ISSUE_QUEUE -- requirements
Module: id_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of decoded-instruction entries; the value SHALL be a power of two and at least 2.
REQ-002 SHALL have port clk_i  input  1  the single clock.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port flush_i  input  1  discard all buffered entries (mispredict or exception).
REQ-005 SHALL have port instr_i  input  scoreboard_entry_t  decoded instruction from the decoder.
REQ-006 SHALL have port instr_valid_i  input  1  instr_i is valid this cycle.
REQ-007 SHALL have port is_ctrl_flow_i  input  1  instr_i is a control-flow instruction.
REQ-008 SHALL have port instr_ready_o  output  1  queue can accept a push this cycle.
REQ-009 SHALL have port decoded_instr_o  output  scoreboard_entry_t  head entry toward issue.
REQ-010 SHALL have port decoded_instr_valid_o  output  1  head entry is valid.
REQ-011 SHALL have port is_ctrl_flow_o  output  1  control-flow flag of the head entry.
REQ-012 SHALL have port decoded_instr_ack_i  input  1  issue consumed the head entry.
REQ-013 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL implement a circular buffer of DEPTH entries, each storing the scoreboard_entry_t and one ctrl-flow bit.
REQ-015 SHALL hold write pointer, read pointer ($clog2(DEPTH) bits, wrapping DEPTH-1 -> 0) and occupancy counter ($clog2(DEPTH)+1 bits).
REQ-016 SHALL drive instr_ready_o = (count_o < DEPTH) combinationally from registered state only; instr_ready_o SHALL NOT depend on decoded_instr_ack_i.
REQ-017 SHALL perform a push when instr_valid_i && instr_ready_o && !flush_i: write the entry at the write pointer, advance it by one.
REQ-018 SHALL drive decoded_instr_valid_o = (count_o != 0) && !flush_i; no fall-through: a pushed entry becomes visible at the head the cycle after its push at the earliest.
REQ-019 SHALL drive decoded_instr_o and is_ctrl_flow_o from the entry at the read pointer; their value when decoded_instr_valid_o is low is don't-care.
REQ-020 SHALL perform a pop when decoded_instr_ack_i && decoded_instr_valid_o: advance the read pointer by one; an ack with decoded_instr_valid_o low SHALL be ignored.
REQ-021 SHALL update count_o by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-022 SHALL keep the head entry and its outputs stable while decoded_instr_valid_o is high and no pop occurs (valid/ack hold rule).
REQ-023 SHALL, when flush_i is high, on the next edge set both pointers and count_o to zero; any push or pop in that cycle SHALL be discarded.
REQ-024 SHALL preserve FIFO order across pointer wrap-around.
REQ-025 SHALL, when full, accept a push only after count_o has dropped below DEPTH; a pop in the full cycle SHALL NOT enable a same-cycle push.

Reset
REQ-026 SHALL, while rst_ni is low, asynchronously force pointers and count_o to 0, giving decoded_instr_valid_o=0, instr_ready_o=1, count_o=0.
REQ-027 SHALL NOT reset entry storage; contents are don't-care until written.
REQ-028 SHALL, on reset asserted mid-operation, discard all entries; after release, the first pushed entry SHALL be the first popped.

Verification
REQ-029 Reset then push A (pc=0x100) cycle 1, ack held high -> valid_o rises cycle 2 with pc=0x100, pops at end of cycle 2, count_o returns to 0 in cycle 3.
REQ-030 DEPTH=4, push 4 entries with no ack -> count_o=4, instr_ready_o=0; a 5th valid push is dropped; one ack -> ready returns next cycle, count_o=3.
REQ-031 Push and ack every cycle for 10 cycles with pcs 0x0,0x4,... -> outputs appear in order, count_o constant, pointers wrap with no loss or duplication.
REQ-032 Fill to 3 entries, assert flush_i with simultaneous push and ack -> valid_o low in flush cycle, count_o=0 next cycle, flushed and same-cycle-pushed entries never appear.
REQ-033 Push ctrl-flow entry (is_ctrl_flow_i=1) then non-ctrl -> is_ctrl_flow_o=1 for first head, 0 after its pop; ack held low 5 cycles -> head outputs stable throughout.
REQ-034 Assert rst_ni low with 2 entries buffered mid-cycle -> valid_o=0 and count_o=0 immediately, without waiting for a clock edge.
